// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
//   Shared definitions for the pipelined barrel shifter:
//   - opcode constants (SRL keeps 3'b011 across the codebase)
//   - is_legal_op : true for the four shift opcodes
//   - popcount    : number of set bits, used to derive pipeline latency
//   - shift_step  : one 2^k level of the barrel shifter, width-generic
// -----------------------------------------------------------------------------
package shifter_pkg;

  // Widest datapath supported; shift_step works on this width internally.
  localparam int MAX_W = 64;

  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROTR = 3'b101;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROTR);
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // One barrel level: shift by 2^k when amt_bit is set. data must be
  // zero above bit width-1. Unknown opcodes pass through untouched; the
  // top level has already forced their data to zero.
  function automatic logic [MAX_W-1:0] shift_step(
    input logic [MAX_W-1:0] data,
    input logic [2:0]       op,
    input logic             sign,
    input logic             amt_bit,
    input int               k,
    input int               width
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] fill;
    int               s;
    s    = 1 << k;
    // (1 << 64) wraps to 0 and 0 - 1 is all ones, so width = 64 needs no special case.
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    // Ones in the top s bits of the active width, used for sign extension.
    fill = ((MAX_W'(1) << s) - MAX_W'(1)) << (width - s);
    shift_step = data;
    if (amt_bit) begin
      case (op)
        OP_SLL:  shift_step = (data << s) & mask;
        OP_SRL:  shift_step = data >> s;
        OP_SRA:  shift_step = (data >> s) | (sign ? fill : '0);
        OP_ROTR: shift_step = ((data >> s) | (data << (width - s))) & mask;
        default: shift_step = data;
      endcase
    end
  endfunction

endpackage

// File: rtl/pipelined_shifter_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
//   One level of the barrel shifter (shift by 2^K under amount bit K) with an
//   optional valid/ready register slice on its output.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     i_valid / o_ready   upstream handshake
//     i_data/op/amt/sign  upstream payload
//     o_valid / i_ready   downstream handshake
//     o_data/op/amt/sign  downstream payload (shifted data, rest forwarded)
// -----------------------------------------------------------------------------
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int K          = 0,
  parameter bit REGISTERED = 1'b0,
  parameter int SHW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_op,
  input  logic [SHW-1:0]   i_amt,
  input  logic             i_sign,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [2:0]       o_op,
  output logic [SHW-1:0]   o_amt,
  output logic             o_sign
);

  logic [WIDTH-1:0] w_shifted;

  assign w_shifted = WIDTH'(shift_step(MAX_W'(i_data), i_op, i_sign, i_amt[K], K, WIDTH));

  if (REGISTERED) begin : g_reg
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_op;
    logic [SHW-1:0]   r_amt;
    logic             r_sign;

    // Accept when empty or when the held item leaves this cycle, so bubbles
    // collapse instead of stalling the whole pipe.
    assign o_ready = !r_valid || i_ready;

    // NOTE: non-blocking assignments make every slice load from pre-edge
    // values, so neighbouring slices shift in lockstep.
    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: payload registers are cleared as well so dataOut reads 0
        // right after reset, not just out_valid.
        r_valid <= 1'b0;
        r_data  <= '0;
        r_op    <= '0;
        r_amt   <= '0;
        r_sign  <= 1'b0;
      end else if (o_ready) begin
        r_valid <= i_valid;
        if (i_valid) begin
          r_data <= w_shifted;
          r_op   <= i_op;
          r_amt  <= i_amt;
          r_sign <= i_sign;
        end
      end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_op    = r_op;
    assign o_amt   = r_amt;
    assign o_sign  = r_sign;
  end else begin : g_comb
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    assign o_ready = i_ready;
    assign o_valid = i_valid;
    assign o_data  = w_shifted;
    assign o_op    = i_op;
    assign o_amt   = i_amt;
    assign o_sign  = i_sign;
  end

endmodule

// File: rtl/pipelined_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_shifter
//   Parametrised barrel shifter (SLL/SRL/SRA/ROTR) built from SHW cascaded
//   2^k stages; REG_MASK bit k places a register slice after stage k.
//   Latency = popcount(REG_MASK); REG_MASK = 0 gives a combinational shifter.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid, in_ready    request handshake
//     dataA, dataB, Signal  operand, shift amount, opcode
//     out_valid, out_ready  result handshake
//     dataOut               result (0 for illegal opcodes)
// -----------------------------------------------------------------------------
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int             WIDTH    = 32,
  parameter int             SHW      = $clog2(WIDTH),
  parameter logic [SHW-1:0] REG_MASK = SHW'(20)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [SHW-1:0]   dataB,
  input  logic [2:0]       Signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut
);

  // Illegal opcodes enter the pipe as zero data; every stage passes them
  // through unchanged, so the result is zero yet the handshake completes.
  logic [WIDTH-1:0] w_in_data;
  assign w_in_data = is_legal_op(Signal) ? dataA : '0;

  // Each stage owns its own wires so that the forward data chain and the
  // backward ready chain never share one variable.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             w_up_valid;
    logic             w_up_ready;
    logic [WIDTH-1:0] w_up_data;
    logic [2:0]       w_up_op;
    logic [SHW-1:0]   w_up_amt;
    logic             w_up_sign;
    logic             w_dn_valid;
    logic             w_dn_ready;
    logic [WIDTH-1:0] w_dn_data;
    logic [2:0]       w_dn_op;
    logic [SHW-1:0]   w_dn_amt;
    logic             w_dn_sign;

    if (k == 0) begin : g_src
      assign w_up_valid = in_valid;
      assign w_up_data  = w_in_data;
      assign w_up_op    = Signal;
      assign w_up_amt   = dataB;
      assign w_up_sign  = dataA[WIDTH-1];
    end else begin : g_chain
      assign w_up_valid = g_stage[k-1].w_dn_valid;
      assign w_up_data  = g_stage[k-1].w_dn_data;
      assign w_up_op    = g_stage[k-1].w_dn_op;
      assign w_up_amt   = g_stage[k-1].w_dn_amt;
      assign w_up_sign  = g_stage[k-1].w_dn_sign;
    end

    if (k == SHW - 1) begin : g_last
      logic w_unused_tail;
      assign w_unused_tail = ^{w_dn_op, w_dn_amt, w_dn_sign};
      assign w_dn_ready    = out_ready;
    end else begin : g_mid
      assign w_dn_ready = g_stage[k+1].w_up_ready;
    end

    shift_stage #(
      .WIDTH     (WIDTH),
      .K         (k),
      .REGISTERED(REG_MASK[k]),
      .SHW       (SHW)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_valid(w_up_valid),
      .o_ready(w_up_ready),
      .i_data (w_up_data),
      .i_op   (w_up_op),
      .i_amt  (w_up_amt),
      .i_sign (w_up_sign),
      .o_valid(w_dn_valid),
      .i_ready(w_dn_ready),
      .o_data (w_dn_data),
      .o_op   (w_dn_op),
      .o_amt  (w_dn_amt),
      .o_sign (w_dn_sign)
    );
  end

  assign in_ready  = g_stage[0].w_up_ready;
  assign out_valid = g_stage[SHW-1].w_dn_valid;
  assign dataOut   = g_stage[SHW-1].w_dn_data;

endmodule

// File: tb/tb_pipelined_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_shifter
//   Two instances: WIDTH=32 with REG_MASK=5'b10100 (two slices, latency 2)
//   and WIDTH=8 with REG_MASK=0 (combinational). A bit-level reference model
//   and an in-flight queue predict every result; a negedge monitor compares
//   the 32-bit DUT each cycle, directed cases pin literal values.
// -----------------------------------------------------------------------------
module tb_pipelined_shifter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] dataA, dataOut;
  logic [4:0]  dataB;
  logic [2:0]  Signal;

  logic        v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready;
  logic [7:0]  v8_dataA, v8_dataOut;
  logic [2:0]  v8_dataB;
  logic [2:0]  v8_Signal;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_pop    = 0;
  bit strict_lat;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } item_t;
  item_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_shifter #(.WIDTH(32), .REG_MASK(5'b10100)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .out_valid(out_valid), .out_ready(out_ready), .dataOut(dataOut)
  );

  pipelined_shifter #(.WIDTH(8), .REG_MASK(3'b000)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .dataA(v8_dataA), .dataB(v8_dataB), .Signal(v8_Signal),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready), .dataOut(v8_dataOut)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-by-bit definition of each operation on a w-bit word.
  function automatic logic [63:0] ref_shift(input int w, input logic [2:0] op,
                                            input logic [63:0] a, input int b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        3'b010:  r[i] = (i >= b) ? a[i-b] : 1'b0;
        3'b011:  r[i] = (i + b < w) ? a[i+b] : 1'b0;
        3'b100:  r[i] = (i + b < w) ? a[i+b] : a[w-1];
        3'b101:  r[i] = a[(i+b)%w];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Monitor: inputs change at posedge+1, so negedge sees the values the next
  // edge will act on.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clk) begin
    logic [63:0] e64;
    item_t       it;
    int          age;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(dataOut), 64'(prev_data));
      end
      check("in_ready", 64'(in_ready), 64'(!(q.size() == LAT && !out_ready)));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          it  = q.pop_front();
          age = cyc - it.cyc;
          n_pop++;
          check("result", 64'(dataOut), 64'(it.res));
          if (strict_lat) check("latency", 64'(age), 64'(LAT));
          else            check("latency_min", 64'(age >= LAT), 64'd1);
        end
      end
      if (in_valid && in_ready) begin
        e64 = ref_shift(32, Signal, 64'(dataA), int'(dataB));
        it.res = e64[31:0];
        it.cyc = cyc;
        q.push_back(it);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = dataOut;
    end
  end

  task automatic drive_rand();
    in_valid = 1'b1;
    dataA    = $urandom;
    dataB    = 5'($urandom_range(0, 31));
    Signal   = 3'($urandom_range(0, 7));
  endtask

  task automatic send_one(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [4:0] b, input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; Signal = op; dataA = a; dataB = b;
    @(posedge clk); #1;
    // Idle pipe with out_ready high: accepted on that edge. Scramble inputs.
    in_valid = 1'b0; dataA = $urandom; dataB = 5'($urandom_range(0, 31));
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_cycles"}, 64'(n), 64'(LAT));
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_data"}, 64'(dataOut), 64'(exp));
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input string name, input int n, input bit rand_ready);
    int sent, cycles;
    bit fired;
    sent = 0; cycles = 0;
    @(posedge clk); #1;
    drive_rand();
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while (sent < n && cycles < 5000) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      if (fired) sent++;
      @(posedge clk); #1;
      cycles++;
      if (sent >= n) in_valid = 1'b0;
      else if (fired) drive_rand();
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    in_valid = 1'b0;
    check({name, "_sent"}, 64'(sent), 64'(n));
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_drained"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [63:0] e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dataA = '0; dataB = '0; Signal = '0; strict_lat = 1'b1;
    v8_in_valid = 1'b0; v8_out_ready = 1'b1; v8_dataA = '0; v8_dataB = '0; v8_Signal = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_dataOut", 64'(dataOut), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    send_one("srl", 3'b011, 32'h8000_0000, 5'd31, 32'h0000_0001);
    send_one("sra", 3'b100, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    send_one("sll", 3'b010, 32'h0000_0001, 5'd4,  32'h0000_0010);
    send_one("rotr", 3'b101, 32'h0000_000F, 5'd4, 32'hF000_0000);
    send_one("illegal", 3'b111, 32'hDEAD_BEEF, 5'd3, 32'h0000_0000);
    send_one("zero_amt", 3'b101, 32'h1234_5678, 5'd0, 32'h1234_5678);

    // Full-throughput stream.
    p0 = n_pop;
    run_stream("stream", 100, 1'b0);
    drain("stream");
    check("stream_count", 64'(n_pop - p0), 64'd100);

    // Random backpressure with continuous requests.
    strict_lat = 1'b0;
    p0 = n_pop;
    run_stream("stall", 150, 1'b1);
    drain("stall");
    check("stall_count", 64'(n_pop - p0), 64'd150);

    // Reset with two items held in the pipe.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_rand();
    @(posedge clk); #1;
    drive_rand();
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("prerst_out_valid", 64'(out_valid), 64'd1);
    check("prerst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("postrst_out_valid", 64'(out_valid), 64'd0);
    check("postrst_dataOut", 64'(dataOut), 64'd0);
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("postrst_no_stale", 64'(out_valid), 64'd0);

    // Combinational 8-bit instance.
    v8_in_valid = 1'b1; v8_out_ready = 1'b1;
    v8_Signal = 3'b100; v8_dataA = 8'h90; v8_dataB = 3'd2;
    #1;
    check("w8_sra", 64'(v8_dataOut), 64'hE4);
    check("w8_out_valid", 64'(v8_out_valid), 64'd1);
    check("w8_in_ready", 64'(v8_in_ready), 64'd1);
    v8_out_ready = 1'b0;
    #1 check("w8_backpressure", 64'(v8_in_ready), 64'd0);
    v8_in_valid = 1'b0;
    #1 check("w8_valid_drop", 64'(v8_out_valid), 64'd0);
    v8_in_valid = 1'b1; v8_out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      v8_dataA  = 8'($urandom);
      v8_dataB  = 3'($urandom_range(0, 7));
      v8_Signal = 3'($urandom_range(0, 7));
      #1;
      e = ref_shift(8, v8_Signal, 64'(v8_dataA), int'(v8_dataB));
      check("w8_random", 64'(v8_dataOut), e);
    end
    v8_in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
